// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
//   Shared definitions for the bit-serial adder:
//     - state_e       : FSM state encoding (IDLE / RUN / DONE)
//     - DEFAULT_WIDTH : default operand width, shared by the top level and bench
// -----------------------------------------------------------------------------
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

endpackage : serial_adder_pkg

// File: rtl/full_adder_bit.sv
// -----------------------------------------------------------------------------
// full_adder_bit
//   One-bit full adder made of two half adders and an OR gate.
//   Ports:
//     a, b : operand bits
//     cin  : carry in
//     s    : sum bit
//     cout : carry out
// -----------------------------------------------------------------------------
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic s0;
  logic c0;
  logic c1;

  half_adder u_ha0 (
    .a (a),
    .b (b),
    .s (s0),
    .c (c0)
  );

  half_adder u_ha1 (
    .a (s0),
    .b (cin),
    .s (s),
    .c (c1)
  );

  // At most one of the two half-adder carries can be set, so OR suffices.
  assign cout = c0 | c1;

endmodule : full_adder_bit

// File: rtl/half_adder.sv
// -----------------------------------------------------------------------------
// half_adder
//   One-bit half adder, the team's existing combinational building block.
//   Ports:
//     a, b : input bits
//     s    : sum bit   (a ^ b)
//     c    : carry bit (a & b)
// -----------------------------------------------------------------------------
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule : half_adder

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop, LSB
//   first, one bit per clock, with a start/busy/done handshake.
//
//   Parameters:
//     WIDTH    : operand / sum width (2..32)
//   Ports:
//     clk      : clock, rising edge
//     rst_n    : asynchronous active-low reset
//     start    : request to begin; accepted in IDLE or DONE
//     a, b     : operands, captured only on the accepting edge
//     sub      : (only with SERIAL_ADDER_SUB_EN) 1 = compute a - b
//     busy     : high while bits are being processed
//     done     : one-cycle pulse when sum/cout/overflow become valid
//     sum      : result, updated only on the DONE entry edge
//     cout     : unsigned carry out of the MSB (no-borrow when subtracting)
//     overflow : signed overflow (carry into MSB ^ carry out of MSB)
//
//   Build option:
//     SERIAL_ADDER_SUB_EN : adds the sub input for two's-complement subtract.
// -----------------------------------------------------------------------------
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int             CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q,    state_d;
  logic [WIDTH-1:0] a_sh_q,     a_sh_d;
  logic [WIDTH-1:0] b_sh_q,     b_sh_d;
  logic [WIDTH-1:0] res_sh_q,   res_sh_d;
  logic             carry_q,    carry_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic             busy_q,     busy_d;
  logic             done_q,     done_d;
  logic [WIDTH-1:0] sum_q,      sum_d;
  logic             cout_q,     cout_d;
  logic             overflow_q, overflow_d;

  logic             fa_s;
  logic             fa_cout;
  logic             accept;
  logic             sub_sel;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_sel = sub;
`else
  assign sub_sel = 1'b0;
`endif

  full_adder_bit u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // New operands are taken in IDLE and also in DONE, which gives
  // back-to-back operation without an extra idle cycle.
  assign accept = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  always_comb begin
    state_d    = state_q;
    a_sh_d     = a_sh_q;
    b_sh_d     = b_sh_q;
    res_sh_d   = res_sh_q;
    carry_d    = carry_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = done_q;
    sum_d      = sum_q;
    cout_d     = cout_q;
    overflow_d = overflow_q;

    case (state_q)
      ST_IDLE: begin
        done_d = 1'b0;
      end

      ST_RUN: begin
        // Result fills from the top so that after WIDTH shifts bit 0 of the
        // operands has landed in bit 0 of the result.
        res_sh_d = {fa_s, res_sh_q[WIDTH-1:1]};
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        carry_d  = fa_cout;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d    = ST_DONE;
          sum_d      = {fa_s, res_sh_q[WIDTH-1:1]};
          cout_d     = fa_cout;
          // carry_q is the carry into the MSB while the last bit is added.
          overflow_d = carry_q ^ fa_cout;
          busy_d     = 1'b0;
          done_d     = 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        done_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase

    if (accept) begin
      state_d = ST_RUN;
      a_sh_d  = a;
      // Subtraction is a + ~b + 1: invert b on capture and seed carry with 1.
      b_sh_d  = sub_sel ? ~b : b;
      carry_d = sub_sel;
      cnt_d   = '0;
      busy_d  = 1'b1;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      res_sh_q   <= '0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_sh_q     <= a_sh_d;
      b_sh_q     <= b_sh_d;
      res_sh_q   <= res_sh_d;
      carry_q    <= carry_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sum_q      <= sum_d;
      cout_q     <= cout_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = overflow_q;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//   Directed, table-driven bench for serial_adder at WIDTH=8, plus hand-written
//   sequences for back-to-back operation and reset during RUN.
// -----------------------------------------------------------------------------
module tb_serial_adder;
  import serial_adder_pkg::*;

  localparam int W = DEFAULT_WIDTH;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub_i;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  int checks   = 0;
  int failures = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
`ifdef SERIAL_ADDER_SUB_EN
    .sub      (sub_i),
`endif
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit reached");
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Wait for done, sampling #1 after each rising edge; returns edge count.
  task automatic wait_done(input int budget, output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!done && lat < budget);
  endtask

  // Launch one operation, scramble operands during RUN, check the result.
  task automatic run_vec(input vec_t v, input logic [W-1:0] prev_sum, input int idx);
    int lat;
    string tag;
    tag = $sformatf("vec%0d", idx);
    @(negedge clk);
    a = v.a; b = v.b; sub_i = v.sub; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = ~v.a; b = v.b ^ 8'h5A; sub_i = ~v.sub;
    chk({tag, "_busy_after_accept"}, 32'(busy), 32'd1);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 4) chk({tag, "_sum_stable_in_run"}, 32'(sum), 32'(prev_sum));
    end while (!done && lat < 40);
    chk({tag, "_latency"}, 32'(lat), 32'(W));
    chk({tag, "_sum"},  32'(sum),      32'(v.sum));
    chk({tag, "_cout"}, 32'(cout),     32'(v.cout));
    chk({tag, "_ovf"},  32'(overflow), 32'(v.ovf));
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_done_pulse_end"}, 32'(done), 32'd0);
  endtask

  initial begin
    int lat;
    int gap;
    logic [W-1:0] prev;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; sub_i = 1'b0;

    //               a      b     sub   sum    cout  ovf
    vecs.push_back('{8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0});
    vecs.push_back('{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0});
    vecs.push_back('{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1});
    vecs.push_back('{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1});
    vecs.push_back('{8'h3C, 8'hC4, 1'b0, 8'h00, 1'b1, 1'b0});
    vecs.push_back('{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 1'b0});
    vecs.push_back('{8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1});
    vecs.push_back('{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0});
`ifdef SERIAL_ADDER_SUB_EN
    vecs.push_back('{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0});
    vecs.push_back('{8'h07, 8'h05, 1'b1, 8'h02, 1'b1, 1'b0});
    vecs.push_back('{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1});
`endif

    // Reset then idle
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum",  32'(sum),  32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf",  32'(overflow), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);

    // Table of single operations
    prev = '0;
    foreach (vecs[i]) begin
      run_vec(vecs[i], prev, i);
      prev = vecs[i].sum;
    end

    // Back-to-back: start held high, second operands presented during RUN
    @(negedge clk);
    a = 8'h10; b = 8'h20; sub_i = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 8'h01; b = 8'h02;
    wait_done(40, lat);
    chk("b2b_first_latency", 32'(lat), 32'(W));
    chk("b2b_first_sum", 32'(sum), 32'h30);
    wait_done(40, gap);
    start = 1'b0;
    chk("b2b_done_gap", 32'(gap), 32'(W + 1));
    chk("b2b_second_sum", 32'(sum), 32'h03);
    chk("b2b_second_cout", 32'(cout), 32'd0);
    @(posedge clk); #1;
    chk("b2b_back_idle_busy", 32'(busy), 32'd0);
    chk("b2b_back_idle_done", 32'(done), 32'd0);

    // Reset asserted at bit 4 of an operation
    @(negedge clk);
    a = 8'h33; b = 8'h44; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_sum",  32'(sum),  32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    gap = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) gap++;
    end
    chk("midrst_no_done", 32'(gap), 32'd0);
    chk("midrst_sum_after", 32'(sum), 32'd0);
    chk("midrst_cout_after", 32'(cout), 32'd0);
    chk("midrst_ovf_after", 32'(overflow), 32'd0);

    // Start on the first edge after reset release is accepted
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; a = 8'h11; b = 8'h22; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("rel_start_busy", 32'(busy), 32'd1);
    wait_done(40, lat);
    chk("rel_start_latency", 32'(lat), 32'(W));
    chk("rel_start_sum", 32'(sum), 32'h33);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_serial_adder
